// File: rtl/tag_free_list_pkg.sv
//-----------------------------------------------------------------------------
// Module      : tag_free_list_pkg
// Description : Shared rename-stage constants and types (physical tag,
//               free-list pointer) plus ring-pointer helpers. Reused by the
//               renamer, the ROB and the tag free list.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

package tag_free_list_pkg;

  localparam int NUM_TAGS    = 64;
  localparam int NUM_ARCH    = 32;
  localparam int WIDTH_ALLOC = 3;
  localparam int WIDTH_COM   = 3;

  localparam int DEPTH   = NUM_TAGS - NUM_ARCH;
  localparam int TAG_W   = $clog2(NUM_TAGS);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int AOFF_W  = $clog2(WIDTH_ALLOC + 1);
  localparam int COFF_W  = $clog2(WIDTH_COM + 1);

  typedef logic [TAG_W-1:0] Tag_t;
  typedef logic [PTR_W-1:0] FLPtr_t;
  typedef logic [IDX_W-1:0] FLIdx_t;

  // Pointers live in [0, 2*DEPTH): the upper half is the "wrapped" lap.
  function automatic FLPtr_t ptr_add(FLPtr_t p, FLPtr_t n);
    int s;
    s = int'(p) + int'(n);
    if (s >= 2 * DEPTH) s = s - 2 * DEPTH;
    return FLPtr_t'(s);
  endfunction

  // Distance from b forward to a, modulo the pointer range.
  function automatic FLPtr_t ptr_diff(FLPtr_t a, FLPtr_t b);
    int d;
    d = int'(a) - int'(b);
    if (d < 0) d = d + 2 * DEPTH;
    return FLPtr_t'(d);
  endfunction

  // Storage index of a pointer (drop the lap).
  function automatic FLIdx_t ptr_idx(FLPtr_t p);
    int i;
    i = int'(p);
    if (i >= DEPTH) i = i - DEPTH;
    return FLIdx_t'(i);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tag_free_list_if.sv
//-----------------------------------------------------------------------------
// Module      : tag_free_list_if
// Description : Renamer <-> tag free list bundle. The renamer side is the
//               master (drives IN_*), the free list is the slave (drives OUT_*).
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

interface tag_free_list_if;
  import tag_free_list_pkg::*;

  logic [WIDTH_ALLOC-1:0]       IN_allocReq;
  logic                         IN_allocFire;
  Tag_t [WIDTH_ALLOC-1:0]       OUT_allocTag;
  logic                         OUT_allocReady;
  logic [WIDTH_COM-1:0]         IN_comValid;
  Tag_t [WIDTH_COM-1:0]         IN_comOldTag;
  logic                         IN_flush;
  FLPtr_t                       OUT_freeCount;
  logic                         OUT_dbgErr;

  modport master (
    output IN_allocReq, IN_allocFire, IN_comValid, IN_comOldTag, IN_flush,
    input  OUT_allocTag, OUT_allocReady, OUT_freeCount, OUT_dbgErr
  );

  modport slave (
    input  IN_allocReq, IN_allocFire, IN_comValid, IN_comOldTag, IN_flush,
    output OUT_allocTag, OUT_allocReady, OUT_freeCount, OUT_dbgErr
  );

endinterface

`default_nettype wire

// File: rtl/tag_free_list_prefix_offsets.sv
//-----------------------------------------------------------------------------
// Module      : prefix_offsets
// Description : Exclusive prefix count of a W-bit valid vector: off[k] is the
//               number of set bits below k, total is the population count.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module prefix_offsets #(
  parameter int W  = 3,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]         valid,
  output logic [W-1:0][CW-1:0] off,
  output logic [CW-1:0]        total
);

  // Running count: each slot sees the sum of the valid bits before it.
  always_comb begin : p_prefix
    logic [CW-1:0] acc;
    acc = '0;
    off = '0;
    for (int k = 0; k < W; k++) begin
      off[k] = acc;
      acc    = acc + CW'(valid[k]);
    end
    total = acc;
  end

endmodule

`default_nettype wire

// File: rtl/tag_free_list.sv
//-----------------------------------------------------------------------------
// Module      : tag_free_list
// Description : Circular free list of unmapped physical tags. Hands out up to
//               WIDTH_ALLOC tags per cycle in program order, takes superseded
//               tags back at commit, and rolls the speculative head back to
//               the committed head on flush.
//               Optional checker: define TAG_FREELIST_CHECK_EN to track an
//               isFree bitmap and raise a sticky OUT_dbgErr on misuse.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
`default_nettype none

module tag_free_list
  import tag_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  tag_free_list_if.slave    fl
);

  Tag_t                         r_list [DEPTH];
  FLPtr_t                       r_spec_head;
  FLPtr_t                       r_com_head;
  FLPtr_t                       r_tail;

  logic [WIDTH_ALLOC-1:0][AOFF_W-1:0] w_alloc_off;
  logic [AOFF_W-1:0]                  w_n_alloc;
  logic [WIDTH_COM-1:0][COFF_W-1:0]   w_com_off;
  logic [COFF_W-1:0]                  w_n_com;

  Tag_t [WIDTH_ALLOC-1:0]       w_alloc_tag;
  FLPtr_t                       w_free;
  logic                         w_alloc_ok;
  logic                         w_alloc_do;
  FLPtr_t                       w_com_head_nxt;

  prefix_offsets #(.W(WIDTH_ALLOC), .CW(AOFF_W)) u_alloc_off (
    .valid (fl.IN_allocReq),
    .off   (w_alloc_off),
    .total (w_n_alloc)
  );

  prefix_offsets #(.W(WIDTH_COM), .CW(COFF_W)) u_com_off (
    .valid (fl.IN_comValid),
    .off   (w_com_off),
    .total (w_n_com)
  );

  assign w_free         = ptr_diff(r_tail, r_spec_head);
  assign w_alloc_ok     = (w_free >= FLPtr_t'(w_n_alloc));
  assign w_alloc_do     = fl.IN_allocFire && w_alloc_ok && !fl.IN_flush;
  assign w_com_head_nxt = ptr_add(r_com_head, FLPtr_t'(w_n_com));

  // Requesting slots pack densely from the speculative head.
  generate
    for (genvar k = 0; k < WIDTH_ALLOC; k++) begin : g_alloc_tag
      assign w_alloc_tag[k] =
        r_list[ptr_idx(ptr_add(r_spec_head, FLPtr_t'(w_alloc_off[k])))];
    end
  endgenerate

  assign fl.OUT_allocTag   = w_alloc_tag;
  assign fl.OUT_allocReady = w_alloc_ok;
  assign fl.OUT_freeCount  = w_free;

  // Ring storage and pointers; commit always applies, flush overrides alloc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_list[i] <= Tag_t'(NUM_ARCH + i);
      end
      r_spec_head <= '0;
      r_com_head  <= '0;
      r_tail      <= FLPtr_t'(DEPTH);
    end else begin
      for (int k = 0; k < WIDTH_COM; k++) begin
        if (fl.IN_comValid[k]) begin
          r_list[ptr_idx(ptr_add(r_tail, FLPtr_t'(w_com_off[k])))] <= fl.IN_comOldTag[k];
        end
      end
      r_tail     <= ptr_add(r_tail, FLPtr_t'(w_n_com));
      r_com_head <= w_com_head_nxt;
      if (fl.IN_flush) begin
        r_spec_head <= w_com_head_nxt;
      end else if (w_alloc_do) begin
        r_spec_head <= ptr_add(r_spec_head, FLPtr_t'(w_n_alloc));
      end
    end
  end

`ifdef TAG_FREELIST_CHECK_EN
  logic [NUM_TAGS-1:0] r_is_free;
  logic [NUM_TAGS-1:0] w_is_free_nxt;
  logic                w_err_set;
  logic                r_dbg_err;
  FLPtr_t              w_reclaim_cnt;

  // Squashed allocations sit between the post-commit head and the old spec head.
  assign w_reclaim_cnt = ptr_diff(r_spec_head, w_com_head_nxt);

  // Bitmap update in slot order: allocs clear, frees set, flush reclaims set.
  always_comb begin
    w_is_free_nxt = r_is_free;
    w_err_set     = fl.IN_allocFire && !w_alloc_ok;
    if (w_alloc_do) begin
      for (int k = 0; k < WIDTH_ALLOC; k++) begin
        if (fl.IN_allocReq[k]) begin
          if (!w_is_free_nxt[w_alloc_tag[k]]) w_err_set = 1'b1;
          w_is_free_nxt[w_alloc_tag[k]] = 1'b0;
        end
      end
    end
    for (int k = 0; k < WIDTH_COM; k++) begin
      if (fl.IN_comValid[k]) begin
        if (w_is_free_nxt[fl.IN_comOldTag[k]]) w_err_set = 1'b1;
        w_is_free_nxt[fl.IN_comOldTag[k]] = 1'b1;
      end
    end
    if (fl.IN_flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (FLPtr_t'(i) < w_reclaim_cnt) begin
          w_is_free_nxt[r_list[ptr_idx(ptr_add(w_com_head_nxt, FLPtr_t'(i)))]] = 1'b1;
        end
      end
    end
  end

  // Bitmap register and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < NUM_TAGS; t++) begin
        r_is_free[t] <= (t >= NUM_ARCH);
      end
      r_dbg_err <= 1'b0;
    end else begin
      r_is_free <= w_is_free_nxt;
      if (w_err_set) r_dbg_err <= 1'b1;
    end
  end

  assign fl.OUT_dbgErr = r_dbg_err;
`else
  assign fl.OUT_dbgErr = 1'b0;
`endif

endmodule

`default_nettype wire
